alu_share_arbiter: RTL

- Shares the single combinational ALU between N_REQ requesters, e.g. the execute stage and an address/branch helper unit.
- Arbitrates round-robin, registers the granted operands onto the ALU inputs and captures ALUout/EQ into a result register.
- Returns the result on a valid/ready response channel tagged by a per-requester valid bit.
- Sits between the requesters and the ALU instance; the ALU itself stays unchanged and purely combinational.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/alu_share_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants and types for the ALU sharing arbiter.
//   DATA_W / CTRL_W : operand and control widths of the shared ALU
//   ALU_*           : ALUctrl codes (passed through untouched by the arbiter)
//   state_t         : arbiter FSM states
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 3;

    localparam logic [CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [CTRL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [CTRL_W-1:0] ALU_AND = 3'b010;
    localparam logic [CTRL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [CTRL_W-1:0] ALU_XOR = 3'b100;
    localparam logic [CTRL_W-1:0] ALU_SLT = 3'b101;
    localparam logic [CTRL_W-1:0] ALU_SLL = 3'b110;
    localparam logic [CTRL_W-1:0] ALU_NOP = 3'b111;  // ALU drives 0 for this code

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first asserted request found
// searching upward from ptr_i+1 with wrap-around.
//   req_i       : request vector
//   ptr_i       : index of the most recently granted requester
//   grant_oh_o  : one-hot grant (zero when no request)
//   grant_idx_o : binary index of the grant
//   grant_vld_o : any request granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_oh_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_vld_o
);

    int idx;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        grant_oh_o  = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        idx         = 0;
        // ptr_i < N_REQ, so one conditional subtract implements the wrap.
        for (int off = 1; off <= N_REQ; off++) begin
            idx = int'(ptr_i) + off;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!grant_vld_o && req_i[idx]) begin
                grant_vld_o      = 1'b1;
                grant_oh_o[idx]  = 1'b1;
                grant_idx_o      = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between N_REQ requesters. Round-robin grant in
// IDLE, registered ALU operands for one EXEC cycle, captured result held on a
// one-hot valid/ready response channel in RESP.
//   req_valid/req_ready          : per-requester request handshake
//   req_op1/req_op2/req_ctrl     : packed operands, requester i at [i*W +: W]
//   alu_op1/alu_op2/alu_ctrl     : registered drive into the ALU
//   alu_out/alu_eq               : ALU results
//   rsp_valid/rsp_ready          : one-hot response handshake
//   rsp_result/rsp_eq            : shared response payload
// -----------------------------------------------------------------------------
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int CTRL_W = alu_pkg::CTRL_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_op1,
    input  logic [N_REQ*DATA_W-1:0] req_op2,
    input  logic [N_REQ*CTRL_W-1:0] req_ctrl,
    output logic [DATA_W-1:0]       alu_op1,
    output logic [DATA_W-1:0]       alu_op2,
    output logic [CTRL_W-1:0]       alu_ctrl,
    input  logic [DATA_W-1:0]       alu_out,
    input  logic                    alu_eq,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]       rsp_result,
    output logic                    rsp_eq
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d;
    logic [DATA_W-1:0]   op1_q, op1_d, op2_q, op2_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                eq_q, eq_d;

    logic [N_REQ-1:0]    arb_oh;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_vld;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_oh_o  (arb_oh),
        .grant_idx_o (arb_idx),
        .grant_vld_o (arb_vld)
    );

    // The arbiter only grants asserted valids, so a grant in IDLE is a handshake.
    assign req_ready = (state_q == IDLE) ? arb_oh : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        ctrl_d      = ctrl_q;
        rsp_valid_d = rsp_valid_q;
        result_d    = result_q;
        eq_d        = eq_q;

        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    op1_d    = req_op1[int'(arb_idx)*DATA_W +: DATA_W];
                    op2_d    = req_op2[int'(arb_idx)*DATA_W +: DATA_W];
                    ctrl_d   = req_ctrl[int'(arb_idx)*CTRL_W +: CTRL_W];
                    gnt_d    = arb_idx;
                    rr_ptr_d = arb_idx;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                result_d    = alu_out;
                eq_d        = alu_eq;
                rsp_valid_d = N_REQ'(1) << gnt_q;
                state_d     = RESP;
            end
            RESP: begin
                // Only the granted requester's ready can retire the response.
                if (rsp_ready[gnt_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDX_W'(N_REQ - 1);
            gnt_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            ctrl_q      <= '0;
            rsp_valid_q <= '0;
            result_q    <= '0;
            eq_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            ctrl_q      <= ctrl_d;
            rsp_valid_q <= rsp_valid_d;
            result_q    <= result_d;
            eq_q        <= eq_d;
        end
    end

    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;
    assign alu_ctrl   = ctrl_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_eq     = eq_q;

endmodule
